uart_rx_framer: RTL and testbench
=================================

# uart_rx_framer

Frame controller that sits directly behind the UART receiver. It consumes the receiver's byte stream (done tick plus data byte) and parses length-prefixed, checksummed frames. Payload is buffered until the checksum is verified, then released on a valid/ready byte stream. Bad, truncated or overrunning frames are reported on a one-cycle error strobe with a code.

## Interface
- DATA_WIDTH, 8, byte width; fixed at 8, other values unsupported
- MAX_LEN, 16, maximum payload bytes per frame (1..255)
- SOF, 8'h7E, start-of-frame byte
- TIMEOUT_TICKS, 480, s_tick count without a received byte that aborts an open frame (3 byte times at 16x oversampling)

Ports:
- clk  in  1  system clock
- reset_in  in  1  asynchronous, active-high reset
- s_tick  in  1  oversampling tick, the same one driving the receiver
- rx_done_tick  in  1  one-cycle pulse: rx_data valid
- rx_data  in  8  received byte
- out_valid  out  1  payload byte available
- out_data  out  8  payload byte
- out_last  out  1  final payload byte of the frame (qualified by out_valid)
- out_ready  in  1  downstream accepts out_data
- frame_ok  out  1  one-cycle pulse: frame verified
- frame_err  out  1  one-cycle pulse: frame discarded or byte dropped
- err_code  out  2  valid with frame_err: 00 overrun, 01 bad length, 10 checksum, 11 timeout

One clock. Reset is asynchronous and active-high.

## Operation
- Frame format: SOF, LEN, LEN payload bytes, CSUM.
- A frame is valid when the 8-bit modulo-256 sum of LEN, all payload bytes and CSUM equals 8'h00.
- States and transitions:
  - IDLE: SOF byte goes to LEN. Any other byte is ignored silently, with no error.
  - LEN: byte of 0 or greater than MAX_LEN gives frame_err code 01 and returns to IDLE. Otherwise latch the length, start the sum at LEN, clear the write pointer, and go to PAYLOAD.
  - PAYLOAD: each byte is written to the buffer and added to the sum. After LEN bytes, go to CSUM.
  - CSUM: add the byte to the sum. Sum of 0 pulses frame_ok and goes to DRAIN. Nonzero sum gives frame_err code 10 and returns to IDLE.
  - DRAIN: present buffered bytes in order. After the out_last transfer, return to IDLE.
- Timeout:
  - Counter runs on s_tick in LEN, PAYLOAD and CSUM, and clears on every rx_done_tick.
  - When it reaches TIMEOUT_TICKS: frame_err code 11 and return to IDLE.
  - rx_done_tick and timeout in the same cycle: the byte wins, the counter clears and there is no error.
- Overrun: any rx_done_tick in DRAIN is dropped and gives frame_err code 00. The drain continues unaffected, and a dropped SOF does not open a frame.
- Error and frame_ok strobes never coincide. After any error the buffer contents are discarded.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_last 0, frame_ok 0, frame_err 0, err_code 00, counters 0.
- All outputs are registered.
- The CSUM byte is sampled in cycle N. In cycle N+1, frame_ok or frame_err is high for exactly one cycle. On success, out_valid rises in cycle N+2.
- Handshake:
  - A transfer occurs on a clock edge where out_valid and out_ready are both high.
  - out_data and out_last hold stable while out_valid is high and out_ready is low.
  - With out_ready held high, one byte transfers per cycle.
- out_valid drops in the cycle after the last transfer. A SOF arriving in that same cycle is accepted, since the state is IDLE.
- Reset mid-frame or mid-drain immediately returns to IDLE with outputs at reset values. There is no error strobe.

## Structure
- Shared package uart_pkg holds:
  - state enum (IDLE, LEN, PAYLOAD, CSUM, DRAIN)
  - err_code constants (ERR_OVERRUN, ERR_LEN, ERR_CSUM, ERR_TIMEOUT)
  - default SOF constant
- One sub-module, uart_frame_buf: MAX_LEN x 8 register-file buffer with write port, write pointer and read pointer. Pointers are $clog2(MAX_LEN+1) bits wide.
- The FSM, running sum, length register and timeout counter live in the top level.

## Test plan
- Valid frame 7E 03 11 22 33 97 with out_ready=1 -> frame_ok one cycle; out_data 11, 22, 33 on consecutive cycles; out_last only with 33.
- Frame 7E 02 AA BB 00 -> frame_err, err_code 10; out_valid never asserts.
- LEN bytes 00 and MAX_LEN+1 after SOF -> frame_err, err_code 01. Then 7E 01 05 FA -> frame_ok.
- 7E 02 01 followed by silence for TIMEOUT_TICKS s_ticks -> frame_err, err_code 11. Also a byte landing on the exact timeout tick -> no error.
- Valid 4-byte frame with out_ready=0 while 2 extra bytes arrive -> two frame_err pulses with code 00; data held stable; then out_ready=1 drains all 4 bytes intact.
- Assert reset_in mid-PAYLOAD and mid-DRAIN -> all outputs 0 asynchronously. Next valid frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side frame controller.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } state_e;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file with a write pointer, a read pointer and a shared clear.
module uart_frame_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 16,
    parameter int PTR_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_adv,
    output logic [PTR_W-1:0]      wr_ptr,
    output logic [PTR_W-1:0]      rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Storage rounded up to a power of two so a truncated pointer is always in range.
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << AW;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign wr_ptr  = wr_ptr_q;
    assign rd_ptr  = rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_framer.sv
// Parses SOF/LEN/payload/CSUM frames from the UART receiver and releases verified
// payload on a valid/ready stream, flagging bad, late or overrunning input.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int         DATA_WIDTH    = 8,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SOF           = SOF_DEFAULT,
    parameter int         TIMEOUT_TICKS = 480
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  s_tick,
    input  logic                  rx_done_tick,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DW-1:0] MAX_LEN_B = DW'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_TICKS);

    state_e        state_q, state_d;
    logic [DW-1:0] len_q, len_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          buf_clr, buf_wr, buf_rd_adv;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_next, rd_next;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] sum_add;
    logic [TW-1:0] tmo_inc;
    logic          timeout;

    uart_frame_buf #(
        .DATA_WIDTH(DW),
        .MAX_LEN   (MAX_LEN),
        .PTR_W     (PW)
    ) u_buf (
        .clk    (clk),
        .rst    (reset_in),
        .clr    (buf_clr),
        .wr_en  (buf_wr),
        .wr_data(rx_data),
        .rd_adv (buf_rd_adv),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .rd_data(rd_data)
    );

    assign wr_next = wr_ptr + PW'(1);
    assign rd_next = rd_ptr + PW'(1);
    assign sum_add = sum_q + rx_data;
    assign tmo_inc = tmo_q + TW'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        tmo_d       = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = 2'b00;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        buf_rd_adv  = 1'b0;
        timeout     = 1'b0;

        // A byte landing on the expiring tick clears the counter instead of timing out.
        if (state_q == LEN || state_q == PAYLOAD || state_q == CSUM) begin
            if (!rx_done_tick) begin
                tmo_d = tmo_q;
                if (s_tick) begin
                    if (tmo_inc == TMO_LIM) timeout = 1'b1;
                    else                    tmo_d   = tmo_inc;
                end
            end
        end

        if (timeout) begin
            tmo_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            buf_clr     = 1'b1;
            state_d     = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rx_done_tick && rx_data == SOF) state_d = LEN;
                end
                LEN: begin
                    if (rx_done_tick) begin
                        if (rx_data == '0 || rx_data > MAX_LEN_B) begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_LEN;
                            state_d     = IDLE;
                        end else begin
                            len_d   = rx_data;
                            sum_d   = rx_data;
                            buf_clr = 1'b1;
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_done_tick) begin
                        buf_wr = 1'b1;
                        sum_d  = sum_add;
                        if (DW'(wr_next) == len_q) state_d = CSUM;
                    end
                end
                CSUM: begin
                    if (rx_done_tick) begin
                        if (sum_add == '0) begin
                            frame_ok_d = 1'b1;
                            state_d    = DRAIN;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_CSUM;
                            buf_clr     = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (rx_done_tick) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_OVERRUN;
                    end
                    // Output register refills whenever it is empty or being taken.
                    if (!out_valid_q || out_ready) begin
                        if (out_valid_q && out_last_q) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            buf_clr     = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            out_valid_d = 1'b1;
                            out_data_d  = rd_data;
                            out_last_d  = (DW'(rd_next) == len_q);
                            buf_rd_adv  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: frame parsing, errors, timeout, overrun and reset.
module tb_uart_rx_framer;

    logic       clk;
    logic       reset_in;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor state: written only by the negedge monitor below.
    int         ok_cnt = 0;
    int         err_cnt = 0;
    int         valid_cnt = 0;
    int         coincide_cnt = 0;
    int         stab_bad = 0;
    logic [1:0] last_code = 2'b00;
    logic [7:0] got_data[$];
    bit         got_last[$];
    bit         hold_q = 0;
    logic [7:0] hold_data = 8'h00;
    bit         hold_last = 0;

    uart_rx_framer dut (
        .clk         (clk),
        .reset_in    (reset_in),
        .s_tick      (s_tick),
        .rx_done_tick(rx_done_tick),
        .rx_data     (rx_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset_in) begin
            if (frame_ok) ok_cnt++;
            if (frame_err) begin
                err_cnt++;
                last_code = err_code;
            end
            if (frame_ok && frame_err) coincide_cnt++;
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
            if (out_valid && !out_ready) begin
                if (hold_q && (out_data !== hold_data || out_last !== hold_last)) stab_bad++;
                hold_q    = 1;
                hold_data = out_data;
                hold_last = out_last;
            end else begin
                hold_q = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[], input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[i]);
    endtask

    initial begin
        int         ok0, err0, val0, gbase;
        logic [7:0] f1[] = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        logic [7:0] f2[] = '{8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h00};
        logic [7:0] f3[] = '{8'h7E, 8'h01, 8'h05, 8'hFA};
        logic [7:0] f4[] = '{8'h7E, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h12};
        logic [7:0] exp4[] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

        reset_in     = 1'b1;
        s_tick       = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        out_ready    = 1'b1;
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data",  32'(out_data),  0);
        chk("rst_last",  32'(out_last),  0);
        chk("rst_ok",    32'(frame_ok),  0);
        chk("rst_err",   32'(frame_err), 0);
        chk("rst_code",  32'(err_code),  0);
        ticks(2);
        reset_in = 1'b0;
        ticks(2);

        // Valid frame, cycle-exact output timing
        ok0 = ok_cnt;
        send_frame(f1, 5);
        send_byte(f1[5]);
        @(negedge clk);
        chk("f1_ok_n1",    32'(frame_ok),  1);
        chk("f1_err_n1",   32'(frame_err), 0);
        chk("f1_valid_n1", 32'(out_valid), 0);
        @(negedge clk);
        chk("f1_ok_n2",    32'(frame_ok),  0);
        chk("f1_valid_n2", 32'(out_valid), 1);
        chk("f1_d0",       32'(out_data),  32'h11);
        chk("f1_l0",       32'(out_last),  0);
        @(negedge clk);
        chk("f1_d1", 32'(out_data), 32'h22);
        chk("f1_l1", 32'(out_last), 0);
        @(negedge clk);
        chk("f1_d2", 32'(out_data), 32'h33);
        chk("f1_l2", 32'(out_last), 1);
        @(negedge clk);
        chk("f1_valid_end", 32'(out_valid), 0);
        chk("f1_ok_cnt",    32'(ok_cnt - ok0), 1);
        ticks(2);

        // Checksum error
        ok0 = ok_cnt; err0 = err_cnt; val0 = valid_cnt;
        send_frame(f2, 5);
        ticks(4);
        chk("csum_err_cnt", 32'(err_cnt - err0), 1);
        chk("csum_code",    32'(last_code), 32'h2);
        chk("csum_no_ok",   32'(ok_cnt - ok0), 0);
        chk("csum_no_vld",  32'(valid_cnt - val0), 0);

        // Bad lengths, then a one-byte frame
        err0 = err_cnt;
        send_byte(8'h7E); send_byte(8'h00);
        ticks(2);
        chk("len0_err",  32'(err_cnt - err0), 1);
        chk("len0_code", 32'(last_code), 32'h1);
        send_byte(8'h7E); send_byte(8'h11);
        ticks(2);
        chk("len17_err",  32'(err_cnt - err0), 2);
        chk("len17_code", 32'(last_code), 32'h1);
        ok0 = ok_cnt; gbase = got_data.size();
        send_frame(f3, 4);
        ticks(5);
        chk("f3_ok",   32'(ok_cnt - ok0), 1);
        chk("f3_n",    32'(got_data.size() - gbase), 1);
        chk("f3_d0",   32'(got_data[gbase]), 32'h05);
        chk("f3_l0",   32'(got_last[gbase]), 1);

        // Timeout after 480 silent s_ticks
        err0 = err_cnt;
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'h01);
        s_tick = 1'b1;
        ticks(479);
        s_tick = 1'b0;
        @(negedge clk);
        chk("tmo_pre", 32'(err_cnt - err0), 0);
        tick();
        s_tick = 1'b1;
        tick();
        s_tick = 1'b0;
        ticks(2);
        chk("tmo_err",  32'(err_cnt - err0), 1);
        chk("tmo_code", 32'(last_code), 32'h3);

        // Byte on the expiring tick wins and the frame completes
        err0 = err_cnt; ok0 = ok_cnt;
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'h01);
        s_tick = 1'b1;
        ticks(479);
        send_byte(8'h02);
        s_tick = 1'b0;
        send_byte(8'hFB);
        ticks(6);
        chk("tmo_edge_err", 32'(err_cnt - err0), 0);
        chk("tmo_edge_ok",  32'(ok_cnt - ok0), 1);

        // Overrun while stalled, then drain
        out_ready = 1'b0;
        err0 = err_cnt; ok0 = ok_cnt; gbase = got_data.size();
        send_frame(f4, 7);
        ticks(3);
        send_byte(8'h7E);
        send_byte(8'h01);
        ticks(3);
        chk("ovr_ok",     32'(ok_cnt - ok0), 1);
        chk("ovr_err",    32'(err_cnt - err0), 2);
        chk("ovr_code",   32'(last_code), 32'h0);
        chk("ovr_stable", 32'(stab_bad), 0);
        chk("ovr_hold",   32'(out_data), 32'hA1);
        chk("ovr_coinc",  32'(coincide_cnt), 0);
        out_ready = 1'b1;
        ticks(8);
        chk("ovr_n", 32'(got_data.size() - gbase), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovr_d%0d", i), 32'(got_data[gbase+i]), 32'(exp4[i]));
            chk($sformatf("ovr_l%0d", i), 32'(got_last[gbase+i]), (i == 3) ? 1 : 0);
        end
        chk("ovr_idle_vld", 32'(out_valid), 0);

        // Reset mid-payload
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
        #1 reset_in = 1'b1;
        #1;
        chk("rstp_valid", 32'(out_valid), 0);
        chk("rstp_err",   32'(frame_err), 0);
        tick();
        reset_in = 1'b0;
        ticks(2);

        // Reset mid-drain
        out_ready = 1'b0;
        send_frame(f1, 6);
        ticks(3);
        chk("rstd_pre_vld", 32'(out_valid), 1);
        #1 reset_in = 1'b1;
        #1;
        chk("rstd_valid", 32'(out_valid), 0);
        chk("rstd_data",  32'(out_data),  0);
        chk("rstd_last",  32'(out_last),  0);
        tick();
        reset_in  = 1'b0;
        out_ready = 1'b1;
        ticks(2);

        // Recovery frame after reset
        ok0 = ok_cnt; err0 = err_cnt; gbase = got_data.size();
        send_frame(f1, 6);
        ticks(6);
        chk("rec_ok",  32'(ok_cnt - ok0), 1);
        chk("rec_err", 32'(err_cnt - err0), 0);
        chk("rec_n",   32'(got_data.size() - gbase), 3);
        chk("rec_d0",  32'(got_data[gbase]),   32'h11);
        chk("rec_d1",  32'(got_data[gbase+1]), 32'h22);
        chk("rec_d2",  32'(got_data[gbase+2]), 32'h33);
        chk("rec_l2",  32'(got_last[gbase+2]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
